mod_counter: RTL and testbench

Parametrised up/down modulo counter with programmable step, synchronous load/clear, and selectable wrap or saturate behaviour at the range limits. It generalises the team's single-purpose enable/clear counter so one block can serve as event counter, timeout timer, ring-buffer pointer or credit tracker. It sits in the `i_clk` domain and is instantiated directly by datapath and control blocks.

---
 rtl/mod_counter.sv | 114 +++++++++++
 tb/tb_mod_counter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_counter.sv
// mod_counter: parametrised up/down modulo counter with programmable step,
// synchronous clear/load and selectable wrap or saturate behaviour at the
// range limits 0 and MODULO-1. All outputs are registered.
module mod_counter #(
   parameter int unsigned     WIDTH       = 12,
   parameter longint unsigned MODULO      = 64'd1 << WIDTH,
   parameter bit              SATURATE    = 1'b0,
   parameter longint unsigned RESET_VALUE = 0
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_en,
   input  logic             i_dir,
   input  logic [WIDTH-1:0] i_step,
   input  logic             i_clear,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_load_value,
   output logic [WIDTH-1:0] o_count,
   output logic             o_wrap,
   output logic             o_sat
);

   // All range arithmetic is one bit wider than the count so that
   // count+step and count+MODULO never overflow.
   localparam logic [WIDTH:0]   MOD_X   = (WIDTH+1)'(MODULO);
   localparam logic [WIDTH:0]   MAX_X   = MOD_X - (WIDTH+1)'(1);
   localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VALUE);

   logic [WIDTH-1:0] count_q, count_d;
   logic             wrap_q, wrap_d;
   logic             sat_q, sat_d;

   logic [WIDTH:0] cnt_x;
   logic [WIDTH:0] step_x;
   logic [WIDTH:0] load_x;
   logic [WIDTH:0] up_sum;
   logic           up_over;
   logic           down_under;
   logic [WIDTH:0] res_x;

   assign cnt_x      = {1'b0, count_q};
   assign step_x     = {1'b0, i_step};
   assign load_x     = {1'b0, i_load_value};
   assign up_sum     = cnt_x + step_x;
   assign up_over    = (up_sum >= MOD_X);
   assign down_under = (cnt_x < step_x);

   // Next-state selection: clear beats load beats enabled step beats hold.
   always_comb begin
      count_d = count_q;
      wrap_d  = 1'b0;
      sat_d   = sat_q;
      res_x   = cnt_x;
      if (i_clear) begin
         count_d = '0;
         sat_d   = 1'b0;
      end else if (i_load) begin
         // Out-of-range load values are clamped to the top of the range.
         res_x   = (load_x > MAX_X) ? MAX_X : load_x;
         count_d = res_x[WIDTH-1:0];
         sat_d   = 1'b0;
      end else if (i_en) begin
         sat_d = 1'b0;
         if (i_dir) begin
            if (up_over) begin
               if (SATURATE) begin
                  res_x = MAX_X;
                  sat_d = 1'b1;
               end else begin
                  res_x  = up_sum - MOD_X;
                  wrap_d = 1'b1;
               end
            end else begin
               res_x = up_sum;
            end
         end else begin
            if (down_under) begin
               if (SATURATE) begin
                  res_x = '0;
                  sat_d = 1'b1;
               end else begin
                  res_x  = cnt_x + MOD_X - step_x;
                  wrap_d = 1'b1;
               end
            end else begin
               res_x = cnt_x - step_x;
            end
         end
         count_d = res_x[WIDTH-1:0];
      end
   end

   // State register; reset acts immediately and discards any pending update.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         count_q <= RST_VAL;
         wrap_q  <= 1'b0;
         sat_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         wrap_q  <= wrap_d;
         sat_q   <= sat_d;
      end
   end

   assign o_count = count_q;
   assign o_wrap  = wrap_q;
   assign o_sat   = sat_q;

   // A step of MODULO or more has no meaning for an enabled update.
   step_legal_a: assert property (@(posedge i_clk) disable iff (!i_rst_n)
                                  i_en |-> (step_x < MOD_X));

endmodule

// File: tb/tb_mod_counter.sv
// Bench for mod_counter: four differently parametrised instances share one
// stimulus stream and are compared every cycle against an integer model,
// plus directed checks on the interesting corner cases.
module tb_mod_counter;

   localparam int N = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        en = 1'b0, dir = 1'b0, clr = 1'b0, ld = 1'b0;
   logic [11:0] step = '0, ldv = '0;

   logic [11:0] cnt0;
   logic [3:0]  cnt1;
   logic [4:0]  cnt2;
   logic [4:0]  cnt3;
   logic        wr0, wr1, wr2, wr3;
   logic        st0, st1, st2, st3;

   int n_cmp = 0;
   int n_mis = 0;

   int m_cnt [N];
   int m_wrap[N];
   int m_sat [N];

   always #5 clk = ~clk;

   mod_counter #(.WIDTH(12)) u_big (
      .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_dir(dir), .i_step(step),
      .i_clear(clr), .i_load(ld), .i_load_value(ldv),
      .o_count(cnt0), .o_wrap(wr0), .o_sat(st0));

   mod_counter #(.WIDTH(4), .MODULO(10)) u_wrap (
      .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_dir(dir), .i_step(step[3:0]),
      .i_clear(clr), .i_load(ld), .i_load_value(ldv[3:0]),
      .o_count(cnt1), .o_wrap(wr1), .o_sat(st1));

   mod_counter #(.WIDTH(5), .MODULO(10), .SATURATE(1'b1)) u_sat (
      .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_dir(dir), .i_step(step[4:0]),
      .i_clear(clr), .i_load(ld), .i_load_value(ldv[4:0]),
      .o_count(cnt2), .o_wrap(wr2), .o_sat(st2));

   mod_counter #(.WIDTH(5), .RESET_VALUE(7)) u_rv (
      .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_dir(dir), .i_step(step[4:0]),
      .i_clear(clr), .i_load(ld), .i_load_value(ldv[4:0]),
      .o_count(cnt3), .o_wrap(wr3), .o_sat(st3));

   function automatic int width_of(int d);
      case (d)
         0: return 12;
         1: return 4;
         default: return 5;
      endcase
   endfunction

   function automatic int mod_of(int d);
      case (d)
         0: return 4096;
         1: return 10;
         2: return 10;
         default: return 32;
      endcase
   endfunction

   function automatic bit sat_mode(int d);
      return (d == 2);
   endfunction

   function automatic int rst_of(int d);
      return (d == 3) ? 7 : 0;
   endfunction

   function automatic int obs_cnt(int d);
      case (d)
         0: return int'(cnt0);
         1: return int'(cnt1);
         2: return int'(cnt2);
         default: return int'(cnt3);
      endcase
   endfunction

   function automatic int obs_wrap(int d);
      case (d)
         0: return int'(wr0);
         1: return int'(wr1);
         2: return int'(wr2);
         default: return int'(wr3);
      endcase
   endfunction

   function automatic int obs_sat(int d);
      case (d)
         0: return int'(st0);
         1: return int'(st1);
         2: return int'(st2);
         default: return int'(st3);
      endcase
   endfunction

   task automatic chk(string tag, int obs, int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < N; d++) begin
         m_cnt[d]  = rst_of(d);
         m_wrap[d] = 0;
         m_sat[d]  = 0;
      end
   endtask

   // Behaviour of one rising edge, written directly from the counting rules.
   task automatic model_edge();
      int m, w, s, v, t;
      if (!rst_n) begin
         model_reset();
         return;
      end
      for (int d = 0; d < N; d++) begin
         m = mod_of(d);
         w = width_of(d);
         s = int'(step) % (1 << w);
         v = int'(ldv) % (1 << w);
         m_wrap[d] = 0;
         if (clr) begin
            m_cnt[d] = 0;
            m_sat[d] = 0;
         end else if (ld) begin
            m_cnt[d] = (v > m - 1) ? m - 1 : v;
            m_sat[d] = 0;
         end else if (en) begin
            m_sat[d] = 0;
            t = dir ? m_cnt[d] + s : m_cnt[d] - s;
            if (t >= m) begin
               if (sat_mode(d)) begin m_cnt[d] = m - 1; m_sat[d] = 1; end
               else begin m_cnt[d] = t - m; m_wrap[d] = 1; end
            end else if (t < 0) begin
               if (sat_mode(d)) begin m_cnt[d] = 0; m_sat[d] = 1; end
               else begin m_cnt[d] = t + m; m_wrap[d] = 1; end
            end else begin
               m_cnt[d] = t;
            end
         end
      end
   endtask

   task automatic check_all(string ph);
      for (int d = 0; d < N; d++) begin
         chk($sformatf("%s.cnt%0d", ph, d), obs_cnt(d), m_cnt[d]);
         chk($sformatf("%s.wrap%0d", ph, d), obs_wrap(d), m_wrap[d]);
         chk($sformatf("%s.sat%0d", ph, d), obs_sat(d), m_sat[d]);
      end
   endtask

   task automatic tick(string ph);
      @(posedge clk);
      model_edge();
      #1;
      check_all(ph);
   endtask

   task automatic drive(bit c, bit l, int lv, bit e, bit d, int s);
      clr  = c;
      ld   = l;
      ldv  = 12'(lv);
      en   = e;
      dir  = d;
      step = 12'(s);
   endtask

   initial begin
      // reset from power-up, before any clock edge
      #1 rst_n = 1'b0;
      #1;
      model_reset();
      check_all("rst0");
      chk("rst0.rv", int'(cnt3), 7);
      tick("rst1");
      rst_n = 1'b1;

      // plain up count by 1 on the 4096 counter, then idle
      drive(0, 0, 0, 1, 1, 1);
      for (int i = 0; i < 10; i++) begin
         tick("up1");
         chk("up1.nowrap", int'(wr0), 0);
      end
      chk("up1.count", int'(cnt0), 10);
      drive(0, 0, 0, 0, 1, 1);
      repeat (10) tick("idle");
      chk("idle.count", int'(cnt0), 10);

      // wrap mode, modulo 10
      drive(0, 1, 9, 0, 1, 0); tick("ld9");
      drive(0, 0, 0, 1, 1, 3); tick("wup");
      chk("wup.count", int'(cnt1), 2);
      chk("wup.wrap", int'(wr1), 1);
      drive(0, 0, 0, 0, 1, 3); tick("whold");
      chk("whold.wrap", int'(wr1), 0);
      drive(0, 1, 1, 0, 0, 0); tick("ld1");
      drive(0, 0, 0, 1, 0, 3); tick("wdn");
      chk("wdn.count", int'(cnt1), 8);
      chk("wdn.wrap", int'(wr1), 1);
      drive(0, 0, 0, 1, 1, 7); tick("wb2b1");
      chk("wb2b1.count", int'(cnt1), 5);
      chk("wb2b1.wrap", int'(wr1), 1);
      tick("wb2b2");
      chk("wb2b2.count", int'(cnt1), 2);
      chk("wb2b2.wrap", int'(wr1), 1);

      // saturate mode, modulo 10
      drive(0, 1, 8, 0, 1, 0); tick("ld8");
      drive(0, 0, 0, 1, 1, 5); tick("sup");
      chk("sup.count", int'(cnt2), 9);
      chk("sup.sat", int'(st2), 1);
      drive(0, 0, 0, 0, 1, 5); tick("shold");
      chk("shold.sat", int'(st2), 1);
      drive(0, 0, 0, 1, 1, 0); tick("szero");
      chk("szero.count", int'(cnt2), 9);
      chk("szero.sat", int'(st2), 0);
      drive(0, 0, 0, 1, 0, 9); tick("sexact0");
      chk("sexact0.count", int'(cnt2), 0);
      chk("sexact0.sat", int'(st2), 0);
      drive(0, 0, 0, 1, 0, 1); tick("sunder");
      chk("sunder.count", int'(cnt2), 0);
      chk("sunder.sat", int'(st2), 1);
      drive(0, 0, 0, 1, 1, 9); tick("sexact9");
      chk("sexact9.count", int'(cnt2), 9);
      chk("sexact9.sat", int'(st2), 0);

      // priority between clear, load and enable; load clamping
      drive(1, 1, 5, 1, 1, 1); tick("pclr");
      chk("pclr.count", int'(cnt1), 0);
      drive(0, 1, 5, 1, 1, 1); tick("pld");
      chk("pld.count", int'(cnt1), 5);
      drive(0, 1, 15, 0, 1, 1); tick("pclamp");
      chk("pclamp.count", int'(cnt1), 9);

      // reset mid-operation returns to RESET_VALUE without a clock edge
      drive(1, 0, 0, 0, 1, 0); tick("rclr");
      drive(0, 0, 0, 1, 1, 5);
      repeat (4) tick("rup");
      chk("rup.count", int'(cnt3), 20);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_all("rmid");
      chk("rmid.count", int'(cnt3), 7);
      drive(0, 0, 0, 1, 1, 1);
      tick("rheld");
      rst_n = 1'b1;
      tick("rfirst");
      chk("rfirst.count", int'(cnt3), 8);

      // randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0,
               int'($urandom_range(0, 4095)), $urandom_range(0, 3) != 0,
               $urandom_range(0, 1) == 1, int'($urandom_range(0, 9)));
         tick("rnd");
         if ($urandom_range(0, 49) == 0) begin
            rst_n = 1'b0;
            #1;
            model_reset();
            check_all("rndrst");
            rst_n = 1'b1;
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
